// File: rtl/goruntu_akitici_pkg.sv
// Shared defaults, FSM encoding and a counter-width helper for the frame source.
package goruntu_akitici_pkg;

  localparam int VARSAYILAN_GENISLIK   = 320;
  localparam int VARSAYILAN_YUKSEKLIK  = 240;
  localparam int VARSAYILAN_VERI_BIT   = 8;
  localparam int VARSAYILAN_FILTRE_BIT = 72;
  localparam int VARSAYILAN_ADRES_BIT  = 17;

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    AKIS   = 2'd1,
    BOSALT = 2'd2,
    BITTI  = 2'd3
  } durum_e;

  // A one-entry range still needs a 1-bit counter.
  function automatic int sayac_bit(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/goruntu_akitici_akis_tamponu.sv
// Two-entry output FIFO holding pixel data plus a first-beat flag.
module akis_tamponu #(
  parameter int VERI_BIT = 8
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                yaz_i,
  input  logic [VERI_BIT-1:0] yaz_veri_i,
  input  logic                yaz_ilk_i,
  input  logic                oku_i,
  output logic [VERI_BIT-1:0] veri_o,
  output logic                ilk_o,
  output logic [1:0]          dolu_o
);

  logic [VERI_BIT-1:0] veri_q [2];
  logic [VERI_BIT-1:0] veri_d [2];
  logic [1:0]          ilk_q, ilk_d;
  logic                yaz_ptr_q, yaz_ptr_d;
  logic                oku_ptr_q, oku_ptr_d;
  logic [1:0]          dolu_q, dolu_d;

  // The credit check upstream guarantees no push into a full FIFO and no pop when empty.
  always_comb begin
    veri_d    = veri_q;
    ilk_d     = ilk_q;
    yaz_ptr_d = yaz_ptr_q;
    oku_ptr_d = oku_ptr_q;
    if (yaz_i) begin
      veri_d[yaz_ptr_q] = yaz_veri_i;
      ilk_d[yaz_ptr_q]  = yaz_ilk_i;
      yaz_ptr_d         = ~yaz_ptr_q;
    end
    if (oku_i) begin
      oku_ptr_d = ~oku_ptr_q;
    end
    dolu_d = dolu_q + 2'(yaz_i) - 2'(oku_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      veri_q[0] <= '0;
      veri_q[1] <= '0;
      ilk_q     <= '0;
      yaz_ptr_q <= 1'b0;
      oku_ptr_q <= 1'b0;
      dolu_q    <= '0;
    end else begin
      veri_q[0] <= veri_d[0];
      veri_q[1] <= veri_d[1];
      ilk_q     <= ilk_d;
      yaz_ptr_q <= yaz_ptr_d;
      oku_ptr_q <= oku_ptr_d;
      dolu_q    <= dolu_d;
    end
  end

  assign veri_o = veri_q[oku_ptr_q];
  assign ilk_o  = ilk_q[oku_ptr_q];
  assign dolu_o = dolu_q;

endmodule

// File: rtl/goruntu_akitici.sv
// Frame source: latches a filter on start and streams one WxH image from frame memory
// in raster order, with valid/ready flow control and row/frame end markers.
module goruntu_akitici
  import goruntu_akitici_pkg::*;
#(
  parameter int GENISLIK   = VARSAYILAN_GENISLIK,
  parameter int YUKSEKLIK  = VARSAYILAN_YUKSEKLIK,
  parameter int VERI_BIT   = VARSAYILAN_VERI_BIT,
  parameter int FILTRE_BIT = VARSAYILAN_FILTRE_BIT,
  parameter int ADRES_BIT  = VARSAYILAN_ADRES_BIT
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  baslat_i,
  input  logic [FILTRE_BIT-1:0] filtre_yukle_i,
  output logic                  mesgul_o,
  output logic                  bitti_o,
  output logic                  bellek_oku_o,
  output logic [ADRES_BIT-1:0]  bellek_adres_o,
  input  logic [VERI_BIT-1:0]   bellek_veri_i,
  output logic                  filtre_etkin_o,
  output logic [FILTRE_BIT-1:0] filtre_o,
  output logic                  veri_etkin_o,
  output logic [VERI_BIT-1:0]   veri_o,
  output logic                  satir_sonu_o,
  output logic                  son_piksel_o,
  input  logic                  veri_hazir_i
);

  localparam int SUTUN_BIT = sayac_bit(GENISLIK);
  localparam int SATIR_BIT = sayac_bit(YUKSEKLIK);
  localparam logic [ADRES_BIT-1:0] SON_ADRES = ADRES_BIT'(GENISLIK * YUKSEKLIK - 1);
  localparam logic [SUTUN_BIT-1:0] SON_SUTUN = SUTUN_BIT'(GENISLIK - 1);
  localparam logic [SATIR_BIT-1:0] SON_SATIR = SATIR_BIT'(YUKSEKLIK - 1);

  durum_e                durum_q, durum_d;
  logic [ADRES_BIT-1:0]  adres_q, adres_d;
  logic                  ucusta_q, ucusta_d;
  logic                  ucusta_ilk_q, ucusta_ilk_d;
  logic [SUTUN_BIT-1:0]  sutun_q, sutun_d;
  logic [SATIR_BIT-1:0]  satir_q, satir_d;
  logic [FILTRE_BIT-1:0] filtre_q, filtre_d;

  logic [VERI_BIT-1:0] tampon_veri;
  logic                tampon_ilk;
  logic [1:0]          tampon_dolu;
  logic                veri_etkin;
  logic                aktarim;
  logic [2:0]          doluluk;
  logic                oku;
  logic                satir_sonu;
  logic                son_piksel;

  akis_tamponu #(
    .VERI_BIT (VERI_BIT)
  ) u_tampon (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .yaz_i      (ucusta_q),
    .yaz_veri_i (bellek_veri_i),
    .yaz_ilk_i  (ucusta_ilk_q),
    .oku_i      (aktarim),
    .veri_o     (tampon_veri),
    .ilk_o      (tampon_ilk),
    .dolu_o     (tampon_dolu)
  );

  assign veri_etkin = (tampon_dolu != 2'd0);
  assign aktarim    = veri_etkin && veri_hazir_i;

  // Occupancy after this cycle's pop; counting the pop keeps reads back-to-back at full rate.
  assign doluluk = {1'b0, tampon_dolu} + {2'b00, ucusta_q} - {2'b00, aktarim};
  assign oku     = (durum_q == AKIS) && (doluluk < 3'd2);

  assign satir_sonu = veri_etkin && (sutun_q == SON_SUTUN);
  assign son_piksel = satir_sonu && (satir_q == SON_SATIR);

  always_comb begin
    durum_d      = durum_q;
    adres_d      = adres_q;
    sutun_d      = sutun_q;
    satir_d      = satir_q;
    filtre_d     = filtre_q;
    ucusta_d     = oku;
    ucusta_ilk_d = oku && (adres_q == '0);

    case (durum_q)
      BOSTA: begin
        if (baslat_i) begin
          durum_d  = AKIS;
          adres_d  = '0;
          sutun_d  = '0;
          satir_d  = '0;
          filtre_d = filtre_yukle_i;
        end
      end
      AKIS: begin
        if (oku && (adres_q == SON_ADRES)) begin
          durum_d = BOSALT;
        end
      end
      BOSALT: begin
        if (aktarim && son_piksel) begin
          durum_d = BITTI;
        end
      end
      BITTI: begin
        durum_d = BOSTA;
      end
      default: begin
        durum_d = BOSTA;
      end
    endcase

    if (oku && (adres_q != SON_ADRES)) begin
      adres_d = adres_q + ADRES_BIT'(1);
    end

    if (aktarim) begin
      if (sutun_q == SON_SUTUN) begin
        sutun_d = '0;
        satir_d = (satir_q == SON_SATIR) ? '0 : satir_q + SATIR_BIT'(1);
      end else begin
        sutun_d = sutun_q + SUTUN_BIT'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q      <= BOSTA;
      adres_q      <= '0;
      ucusta_q     <= 1'b0;
      ucusta_ilk_q <= 1'b0;
      sutun_q      <= '0;
      satir_q      <= '0;
      filtre_q     <= '0;
    end else begin
      durum_q      <= durum_d;
      adres_q      <= adres_d;
      ucusta_q     <= ucusta_d;
      ucusta_ilk_q <= ucusta_ilk_d;
      sutun_q      <= sutun_d;
      satir_q      <= satir_d;
      filtre_q     <= filtre_d;
    end
  end

  assign mesgul_o       = (durum_q != BOSTA);
  assign bitti_o        = (durum_q == BITTI);
  assign bellek_oku_o   = oku;
  assign bellek_adres_o = adres_q;
  assign filtre_etkin_o = veri_etkin && tampon_ilk;
  assign filtre_o       = filtre_q;
  assign veri_etkin_o   = veri_etkin;
  assign veri_o         = tampon_veri;
  assign satir_sonu_o   = satir_sonu;
  assign son_piksel_o   = son_piksel;

endmodule

// File: tb/tb_goruntu_akitici.sv
// Bench for goruntu_akitici: a 4x3 instance driven from a vector table and a 32x24
// instance exercising stalls, random ready and mid-frame reset.
module tb_goruntu_akitici;

  localparam logic [71:0] FILTRE_A = 72'hFF0001FE0002FF0001;
  localparam logic [71:0] FILTRE_B = 72'h112233445566778899;
  localparam int B_GEN = 32;
  localparam int B_YUK = 24;
  localparam int B_TOPLAM = B_GEN * B_YUK;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  // Small 4x3 instance signals
  logic        baslat_k = 1'b0;
  logic [71:0] filtre_in_k = '0;
  logic        hazir_k = 1'b1;
  logic        mesgul_k, bitti_k, oku_k, fetkin_k, etkin_k, satir_k, son_k;
  logic [3:0]  adres_k;
  logic [7:0]  mem_veri_k = '0;
  logic [7:0]  veri_k;
  logic [71:0] filtre_k;

  // Large 32x24 instance signals
  logic        baslat_b = 1'b0;
  logic [71:0] filtre_in_b = '0;
  logic        hazir_b = 1'b0;
  logic        mesgul_b, bitti_b, oku_b, fetkin_b, etkin_b, satir_b, son_b;
  logic [9:0]  adres_b;
  logic [7:0]  mem_veri_b = '0;
  logic [7:0]  veri_b;
  logic [71:0] filtre_b;

  int toplam = 0;
  int gecen = 0;

  // Large-frame scoreboard state
  int rd_beklenen, beat_idx, okuma_n, beat_n;
  logic son_onceki;
  logic [71:0] filtre_beklenen_b;

  typedef struct {
    logic        baslat;
    logic [71:0] filtre;
    logic        hazir;
    logic        oku;
    logic [3:0]  adres;
    logic        etkin;
    logic [7:0]  veri;
    logic        satir;
    logic        son;
    logic        fetkin;
    logic        bitti;
    logic        mesgul;
    logic [71:0] filtre_cikis;
  } vektor_t;

  vektor_t tablo [17];

  always #5 clk = ~clk;

  goruntu_akitici #(
    .GENISLIK(4), .YUKSEKLIK(3), .VERI_BIT(8), .FILTRE_BIT(72), .ADRES_BIT(4)
  ) dut_k (
    .clk_i(clk), .rstn_i(rstn), .baslat_i(baslat_k), .filtre_yukle_i(filtre_in_k),
    .mesgul_o(mesgul_k), .bitti_o(bitti_k), .bellek_oku_o(oku_k), .bellek_adres_o(adres_k),
    .bellek_veri_i(mem_veri_k), .filtre_etkin_o(fetkin_k), .filtre_o(filtre_k),
    .veri_etkin_o(etkin_k), .veri_o(veri_k), .satir_sonu_o(satir_k), .son_piksel_o(son_k),
    .veri_hazir_i(hazir_k)
  );

  goruntu_akitici #(
    .GENISLIK(B_GEN), .YUKSEKLIK(B_YUK), .VERI_BIT(8), .FILTRE_BIT(72), .ADRES_BIT(10)
  ) dut_b (
    .clk_i(clk), .rstn_i(rstn), .baslat_i(baslat_b), .filtre_yukle_i(filtre_in_b),
    .mesgul_o(mesgul_b), .bitti_o(bitti_b), .bellek_oku_o(oku_b), .bellek_adres_o(adres_b),
    .bellek_veri_i(mem_veri_b), .filtre_etkin_o(fetkin_b), .filtre_o(filtre_b),
    .veri_etkin_o(etkin_b), .veri_o(veri_b), .satir_sonu_o(satir_b), .son_piksel_o(son_b),
    .veri_hazir_i(hazir_b)
  );

  // Synchronous frame memories: ramp for the small frame, ramp xor 5A for the large one
  always @(posedge clk) begin
    if (oku_k) mem_veri_k <= {4'h0, adres_k};
    if (oku_b) mem_veri_b <= adres_b[7:0] ^ 8'h5A;
  end

  task automatic checkOutput(input string ad, input logic [71:0] gercek, input logic [71:0] beklenen);
    toplam++;
    if (gercek !== beklenen)
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", ad, gercek, beklenen, $time);
    else
      gecen++;
  endtask

  task automatic applyStimulus(input vektor_t v);
    baslat_k    = v.baslat;
    filtre_in_k = v.filtre;
    hazir_k     = v.hazir;
  endtask

  // One large-instance cycle: drive at negedge, then score what the DUT shows
  task automatic cycB(input logic hazir, input logic baslat);
    logic son_bu;
    @(negedge clk);
    hazir_b  = hazir;
    baslat_b = baslat;
    #1;
    son_bu = 1'b0;
    if (oku_b) begin
      checkOutput("b_adres", {62'd0, adres_b}, 72'(rd_beklenen));
      rd_beklenen++;
      okuma_n++;
    end
    if (etkin_b && hazir_b) begin
      checkOutput("b_veri", {64'd0, veri_b}, 72'(beat_idx[7:0] ^ 8'h5A));
      checkOutput("b_satir_sonu", {71'd0, satir_b}, 72'((beat_idx % B_GEN) == B_GEN - 1));
      checkOutput("b_son_piksel", {71'd0, son_b}, 72'(beat_idx == B_TOPLAM - 1));
      checkOutput("b_filtre_etkin", {71'd0, fetkin_b}, 72'(beat_idx == 0));
      checkOutput("b_filtre", filtre_b, filtre_beklenen_b);
      son_bu = (beat_idx == B_TOPLAM - 1);
      beat_idx++;
      beat_n++;
    end
    checkOutput("b_kredi", 72'((okuma_n - beat_n) <= 2), 72'd1);
    if (bitti_b) checkOutput("b_bitti_gecikme", {71'd0, son_onceki}, 72'd1);
    son_onceki = son_bu;
  endtask

  task automatic sifirlaSkor();
    rd_beklenen = 0;
    beat_idx    = 0;
    okuma_n     = 0;
    beat_n      = 0;
    son_onceki  = 1'b0;
  endtask

  initial begin
    int n;

    // Vector table for the small frame: full stream, filter check, ignored starts
    for (int c = 0; c < 17; c++) begin
      int k;
      k = c - 3;
      tablo[c].baslat       = (c == 0) || (c == 6) || (c == 15);
      tablo[c].filtre       = (c == 0) ? FILTRE_A : FILTRE_B;
      tablo[c].hazir        = 1'b1;
      tablo[c].oku          = (c >= 1) && (c <= 12);
      tablo[c].adres        = 4'(c - 1);
      tablo[c].etkin        = (k >= 0) && (k <= 11);
      tablo[c].veri         = 8'(k);
      tablo[c].satir        = (k >= 0) && (k <= 11) && ((k % 4) == 3);
      tablo[c].son          = (k == 11);
      tablo[c].fetkin       = (k == 0);
      tablo[c].bitti        = (c == 15);
      tablo[c].mesgul       = (c >= 1) && (c <= 15);
      tablo[c].filtre_cikis = (c == 0) ? 72'd0 : FILTRE_A;
    end

    // Reset state of both instances
    #2;
    checkOutput("k_rst_mesgul", {71'd0, mesgul_k}, 72'd0);
    checkOutput("k_rst_oku", {71'd0, oku_k}, 72'd0);
    checkOutput("k_rst_etkin", {71'd0, etkin_k}, 72'd0);
    checkOutput("k_rst_filtre", filtre_k, 72'd0);
    checkOutput("b_rst_bitti", {71'd0, bitti_b}, 72'd0);
    checkOutput("b_rst_adres", {62'd0, adres_b}, 72'd0);
    checkOutput("b_rst_veri", {64'd0, veri_b}, 72'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      applyStimulus(tablo[c]);
      #1;
      checkOutput($sformatf("k_oku[%0d]", c), {71'd0, oku_k}, {71'd0, tablo[c].oku});
      if (tablo[c].oku)
        checkOutput($sformatf("k_adres[%0d]", c), {68'd0, adres_k}, {68'd0, tablo[c].adres});
      checkOutput($sformatf("k_etkin[%0d]", c), {71'd0, etkin_k}, {71'd0, tablo[c].etkin});
      if (tablo[c].etkin)
        checkOutput($sformatf("k_veri[%0d]", c), {64'd0, veri_k}, {64'd0, tablo[c].veri});
      checkOutput($sformatf("k_satir[%0d]", c), {71'd0, satir_k}, {71'd0, tablo[c].satir});
      checkOutput($sformatf("k_son[%0d]", c), {71'd0, son_k}, {71'd0, tablo[c].son});
      checkOutput($sformatf("k_fetkin[%0d]", c), {71'd0, fetkin_k}, {71'd0, tablo[c].fetkin});
      checkOutput($sformatf("k_bitti[%0d]", c), {71'd0, bitti_k}, {71'd0, tablo[c].bitti});
      checkOutput($sformatf("k_mesgul[%0d]", c), {71'd0, mesgul_k}, {71'd0, tablo[c].mesgul});
      checkOutput($sformatf("k_filtre[%0d]", c), filtre_k, tablo[c].filtre_cikis);
    end
    @(negedge clk);
    baslat_k = 1'b0;

    // Large frame: start with ready low, stall on beat 0, then random ready
    sifirlaSkor();
    filtre_in_b       = FILTRE_B;
    filtre_beklenen_b = FILTRE_B;
    cycB(1'b0, 1'b1);
    n = 0;
    while (!etkin_b && n < 20) begin
      cycB(1'b0, 1'b0);
      n++;
    end
    checkOutput("b_ilk_beat_gorundu", {71'd0, etkin_b}, 72'd1);
    for (int i = 0; i < 10; i++) begin
      cycB(1'b0, 1'b0);
      checkOutput("b_stall_etkin", {71'd0, etkin_b}, 72'd1);
      checkOutput("b_stall_veri", {64'd0, veri_b}, 72'h5A);
      checkOutput("b_stall_fetkin", {71'd0, fetkin_b}, 72'd1);
      checkOutput("b_stall_okuma", 72'(okuma_n <= 2), 72'd1);
    end
    n = 0;
    while (!bitti_b && n < 6000) begin
      cycB(1'($urandom_range(0, 1)), 1'b0);
      n++;
    end
    checkOutput("b_bitti_geldi", {71'd0, bitti_b}, 72'd1);
    checkOutput("b_beat_sayisi", 72'(beat_idx), 72'(B_TOPLAM));
    checkOutput("b_okuma_sayisi", 72'(rd_beklenen), 72'(B_TOPLAM));
    cycB(1'b1, 1'b0);
    checkOutput("b_bosta", {71'd0, mesgul_b}, 72'd0);

    // Mid-frame reset at beat 100, then a clean restart from address 0
    sifirlaSkor();
    filtre_in_b       = FILTRE_A;
    filtre_beklenen_b = FILTRE_A;
    cycB(1'b1, 1'b1);
    n = 0;
    while (beat_idx < 100 && n < 400) begin
      cycB(1'b1, 1'b0);
      n++;
    end
    checkOutput("b_beat100_ulasildi", 72'(beat_idx), 72'd100);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("b_arst_mesgul", {71'd0, mesgul_b}, 72'd0);
    checkOutput("b_arst_bitti", {71'd0, bitti_b}, 72'd0);
    checkOutput("b_arst_oku", {71'd0, oku_b}, 72'd0);
    checkOutput("b_arst_adres", {62'd0, adres_b}, 72'd0);
    checkOutput("b_arst_etkin", {71'd0, etkin_b}, 72'd0);
    checkOutput("b_arst_veri", {64'd0, veri_b}, 72'd0);
    checkOutput("b_arst_fetkin", {71'd0, fetkin_b}, 72'd0);
    checkOutput("b_arst_filtre", filtre_b, 72'd0);
    checkOutput("b_arst_satir", {71'd0, satir_b}, 72'd0);
    checkOutput("b_arst_son", {71'd0, son_b}, 72'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("b_rst_bitti_yok", {71'd0, bitti_b}, 72'd0);
    end
    @(negedge clk);
    rstn = 1'b1;

    sifirlaSkor();
    cycB(1'b1, 1'b1);
    n = 0;
    while (!bitti_b && n < 1500) begin
      cycB(1'b1, 1'b0);
      n++;
    end
    checkOutput("b2_bitti_geldi", {71'd0, bitti_b}, 72'd1);
    checkOutput("b2_beat_sayisi", 72'(beat_idx), 72'(B_TOPLAM));

    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule
